// File: rtl/product_acc_pkg.sv
// Shared definitions for the product accumulator.
//   acc_state_e  : FSM states (IDLE, ACCUM, DONE)
//   ACC_GUARD_W  : extra accumulator bits above the product width
//   MAX_TERMS    : largest supported NO_TERMS; the guard bits are sized so
//                  MAX_TERMS worst-case products never overflow internally
package product_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_e;

    localparam int ACC_GUARD_W = 4;
    localparam int MAX_TERMS   = 16;

endpackage

// File: rtl/sat_clamp.sv
// Saturating narrowing of a signed value.
//   in_i  : IN_W-bit two's-complement value
//   out_o : OUT_W-bit value, clamped to the signed OUT_W range
//   ovf_o : 1 when in_i did not fit and clamping took place
module sat_clamp #(
    parameter int IN_W  = 14,
    parameter int OUT_W = 10
) (
    input  logic [IN_W-1:0]  in_i,
    output logic [OUT_W-1:0] out_o,
    output logic             ovf_o
);

    // The value fits when every bit from the output sign bit upward agrees.
    logic [IN_W-OUT_W:0] top;
    assign top   = in_i[IN_W-1:OUT_W-1];
    assign ovf_o = !((&top) || (~|top));

    always_comb begin
        out_o = in_i[OUT_W-1:0];
        if (ovf_o) begin
            out_o = in_i[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                 : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums NO_TERMS signed products from an upstream multiplier and presents
// the total with a valid/ready handshake.
//   clk, rst           : clock, asynchronous active-high reset
//   clear              : synchronous abort of the accumulation in progress
//   in_product/in_valid/in_ready : product input handshake
//   out_sum/out_valid/out_ready  : result output handshake
//   out_ovf            : result did not fit in 2*NO_BITS signed bits
// Build option: define PRODUCT_ACC_SAT_EN to saturate out_sum and report
// out_ovf; otherwise out_sum wraps and out_ovf is tied low.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int NO_BITS  = 5,
    parameter int NO_TERMS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [2*NO_BITS-1:0] in_product,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [2*NO_BITS-1:0] out_sum,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_ovf
);

    localparam int PW = 2 * NO_BITS;
    localparam int AW = PW + ACC_GUARD_W;
    // The counter is only 4 bits wide, so compare against the index of the
    // last term before incrementing; this keeps NO_TERMS = 16 representable.
    localparam logic [3:0] LAST_IDX = 4'(NO_TERMS - 1);

    acc_state_e    state_q, state_d;
    logic [AW-1:0] acc_q, acc_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] prod_ext;

    assign prod_ext  = {{ACC_GUARD_W{in_product[PW-1]}}, in_product};
    assign in_ready  = (state_q != DONE);
    assign out_valid = (state_q == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        acc_d   = prod_ext;
                        cnt_d   = 4'd1;
                        state_d = (NO_TERMS == 1) ? DONE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc_d = acc_q + prod_ext;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == LAST_IDX) state_d = DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef PRODUCT_ACC_SAT_EN
    logic [PW-1:0] sum_clamped;
    logic          ovf_raw;

    sat_clamp #(.IN_W(AW), .OUT_W(PW)) u_clamp (
        .in_i  (acc_q),
        .out_o (sum_clamped),
        .ovf_o (ovf_raw)
    );

    assign out_sum = sum_clamped;
    // Partial sums may transiently leave the range; only flag the result.
    assign out_ovf = ovf_raw & out_valid;
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc_q[AW-1:PW];
    assign out_sum       = acc_q[PW-1:0];
    assign out_ovf       = 1'b0;
`endif

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic [9:0] in_product;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] out_sum;
    logic       out_valid;
    logic       out_ready;
    logic       out_ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    product_accumulator #(.NO_BITS(5), .NO_TERMS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_product (in_product),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_sum    (out_sum),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ovf    (out_ovf)
    );

    // Advance one clock; land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int v);
        in_product = 10'(v);
        in_valid   = 1'b1;
        step();
        in_valid   = 1'b0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_product = '0; out_ready = 1'b0;
        #12;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 10'd0 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b sum=%0d ovf=%b expected 0/0/0",
                     out_valid, out_sum, out_ovf);
        end
        rst = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_basic();
        send(100); send(200); send(-50);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b expected 0", out_valid);
        end
        send(7);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(257) || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_sum: got valid=%b sum=%0d ovf=%b rdy=%b expected 1/257/0/0",
                     out_valid, $signed(out_sum), out_ovf, in_ready);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: got valid=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        int       exp_pos, exp_neg;
        logic     exp_ovf;
`ifdef PRODUCT_ACC_SAT_EN
        exp_pos = 511;  exp_neg = -512; exp_ovf = 1'b1;
`else
        exp_pos = 176;  exp_neg = -176; exp_ovf = 1'b0;
`endif
        for (int i = 0; i < 4; i++) send(300);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(exp_pos) || out_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_pos: got valid=%b sum=%0d ovf=%b expected 1/%0d/%b",
                     out_valid, $signed(out_sum), out_ovf, exp_pos, exp_ovf);
        end
        consume();
        for (int i = 0; i < 4; i++) send(-300);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(exp_neg) || out_ovf !== exp_ovf) begin
            errors++;
            $display("FAIL ovf_neg: got valid=%b sum=%0d ovf=%b expected 1/%0d/%b",
                     out_valid, $signed(out_sum), out_ovf, exp_neg, exp_ovf);
        end
        consume();
        checks++;
        if (out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cleared: got %b expected 0", out_ovf);
        end
    endtask

    task automatic test_backpressure();
        send(100); send(200); send(-50); send(7);
        in_valid = 1'b1; in_product = 10'(99);
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b1 || out_sum !== 10'(257) || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid=%b sum=%0d rdy=%b expected 1/257/0",
                         i, out_valid, $signed(out_sum), in_ready);
            end
        end
        // in_valid stays high through the release cycle; it must not be taken.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_sum !== 10'd0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b rdy=%b sum=%0d expected 0/1/0",
                     out_valid, in_ready, $signed(out_sum));
        end
        for (int i = 0; i < 4; i++) send(1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(4)) begin
            errors++;
            $display("FAIL bp_next: got valid=%b sum=%0d expected 1/4",
                     out_valid, $signed(out_sum));
        end
        consume();
    endtask

    task automatic test_clear();
        send(100); send(200);
        clear = 1'b1; in_valid = 1'b1; in_product = 10'(50);
        step();
        clear = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 10'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_state: got valid=%b sum=%0d rdy=%b expected 0/0/1",
                     out_valid, $signed(out_sum), in_ready);
        end
        send(1); send(2); send(3);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_count: got valid=%b expected 0", out_valid);
        end
        send(4);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(10)) begin
            errors++;
            $display("FAIL clear_sum: got valid=%b sum=%0d expected 1/10",
                     out_valid, $signed(out_sum));
        end
        // clear also drops a pending result
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_done: got valid=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        send(100); send(200);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_sum !== 10'd0) begin
            errors++;
            $display("FAIL rst_mid_async: got valid=%b sum=%0d expected 0/0",
                     out_valid, $signed(out_sum));
        end
        step();
        rst = 1'b0;
        step();
        send(-1); send(-1); send(-1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_count: got valid=%b expected 0", out_valid);
        end
        send(-1);
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(-4)) begin
            errors++;
            $display("FAIL rst_mid_sum: got valid=%b sum=%0d expected 1/-4",
                     out_valid, $signed(out_sum));
        end
        // reset while a result is pending drops out_valid without a clock edge
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_done_async: got valid=%b rdy=%b expected 0/1", out_valid, in_ready);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_bubbles();
        for (int t = 0; t < 4; t++) begin
            send(5);
            if (t < 3) begin
                step(); step();
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL bubble_gap%0d: got valid=%b expected 0", t, out_valid);
                end
            end
        end
        checks++;
        if (out_valid !== 1'b1 || out_sum !== 10'(20)) begin
            errors++;
            $display("FAIL bubble_sum: got valid=%b sum=%0d expected 1/20",
                     out_valid, $signed(out_sum));
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_bubbles();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter NO_BITS, default 5, operand width of the upstream signed multiplier; products are 2*NO_BITS bits wide.
REQ-002 SHALL have parameter NO_TERMS, default 4, number of products summed per result; legal range 1..16.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear, input, 1, synchronous abort of the current accumulation.
REQ-006 SHALL have port in_product, input, 2*NO_BITS, two's-complement product from the multiplier.
REQ-007 SHALL have port in_valid, input, 1, in_product is valid this cycle.
REQ-008 SHALL have port in_ready, output, 1, block accepts a product this cycle.
REQ-009 SHALL have port out_sum, output, 2*NO_BITS, two's-complement accumulated result.
REQ-010 SHALL have port out_valid, output, 1, out_sum holds a completed result.
REQ-011 SHALL have port out_ready, input, 1, consumer takes out_sum this cycle.
REQ-012 SHALL have port out_ovf, output, 1, result exceeded the 2*NO_BITS signed range.

Function
REQ-013 SHALL keep an internal signed accumulator of 2*NO_BITS+4 bits and a 4-bit term counter; each product is sign-extended before addition.
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE; in_ready = 1 in IDLE and ACCUM, 0 in DONE; out_valid = 1 only in DONE.
REQ-015 SHALL, on input handshake (in_valid & in_ready) in IDLE, load acc = ext(in_product), count = 1, and go to DONE if NO_TERMS = 1, else ACCUM.
REQ-016 SHALL, on input handshake in ACCUM, set acc = acc + ext(in_product), count = count + 1, and go to DONE when the accepted product is term NO_TERMS.
REQ-017 SHALL hold all state when in_valid = 0; no gaps limit exists.
REQ-018 SHALL assert out_valid the cycle after the final term is accepted (latency 1 clock).
REQ-019 SHALL hold out_sum and out_ovf stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL, on out_ready in DONE, return to IDLE with acc = 0, count = 0; a new product is accepted no earlier than the next cycle.
REQ-021 SHALL give clear priority over every handshake: acc = 0, count = 0, state = IDLE, the in-flight product discarded, out_valid low next cycle.
REQ-022 SHALL keep accumulator free of internal overflow for NO_TERMS <= 16 (worst case 16 * 2^(2*NO_BITS-1)).

Reset
REQ-023 SHALL on rst, immediately and regardless of clock: state = IDLE, acc = 0, count = 0, out_valid = 0, out_ovf = 0, out_sum = 0, in_ready = 1 after release.
REQ-024 SHALL abandon any partial accumulation or pending result when rst asserts mid-operation; no result is emitted for it.

Configuration
REQ-025 SHALL, with PRODUCT_ACC_SAT_EN defined, clamp out_sum to [-2^(2*NO_BITS-1), 2^(2*NO_BITS-1)-1] and set out_ovf = 1 when clamping occurred.
REQ-026 SHALL, without PRODUCT_ACC_SAT_EN, drive out_sum = low 2*NO_BITS bits of acc (wrap-around) and tie out_ovf to 0.

Structure
REQ-027 SHALL place the FSM state enum, the accumulator guard width (4) and the NO_TERMS upper bound (16) in shared package product_acc_pkg.
REQ-028 SHALL implement the clamp in one sub-module sat_clamp (wide signed in, narrow signed out, overflow flag), instantiated only under PRODUCT_ACC_SAT_EN.

Verification (NO_BITS = 5, NO_TERMS = 4; output range -512..511)
REQ-029 SHALL test basic sum: products 100, 200, -50, 7 back-to-back -> out_valid one cycle after 4th, out_sum = 257, out_ovf = 0.
REQ-030 SHALL test overflow: four products of 300 -> with macro out_sum = 511, out_ovf = 1; without macro out_sum = 176, out_ovf = 0; four of -300 with macro -> -512, out_ovf = 1.
REQ-031 SHALL test backpressure: result 257 pending, out_ready low 5 cycles -> out_sum stable at 257, in_ready = 0, in_valid ignored; out_ready high -> IDLE next cycle.
REQ-032 SHALL test clear: accept 100, 200, then clear with in_valid = 1 and product 50 -> product dropped; next 1, 2, 3, 4 -> out_sum = 10.
REQ-033 SHALL test reset mid-operation: rst pulsed after 2 of 4 terms -> out_valid = 0 at once, no result emitted; next 4 terms of -1 -> out_sum = -4.
REQ-034 SHALL test bubbles: 4 terms of 5 with in_valid low 2 cycles between each -> out_sum = 20, latency 1 cycle after final handshake.
